decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous and active-high, sampled only on rising edge of clk.
REQ-003 SHALL have inputs D_icode 4, D_ifun 4, D_rA 4, D_rB 4, D_valC 64, D_valP 64, D_stat 4: the decode-stage pipeline register contents.
REQ-004 SHALL have outputs d_srcA 4, d_srcB 4: combinational register-file read addresses, also consumed by the hazard unit.
REQ-005 SHALL have inputs rf_valA 64, rf_valB 64: combinational register-file read data for d_srcA and d_srcB.
REQ-006 SHALL have forwarding inputs e_dstE 4, e_valE 64, M_dstE 4, M_valE 64, M_dstM 4, m_valM 64, W_dstE 4, W_valE 64, W_dstM 4, W_valM 64.
REQ-007 SHALL have input E_bubble, 1: load the bubble into the execute register on the next edge.
REQ-008 SHALL have outputs E_icode 4, E_ifun 4, E_valC 64, E_valA 64, E_valB 64, E_dstE 4, E_dstM 4, E_srcA 4, E_srcB 4, E_stat 4: the registered execute-stage pipeline register.

Function
REQ-009 SHALL treat register ID 0xF as "none"; register 4 is %rsp.
REQ-010 d_srcA SHALL be D_rA for icode 2, 4, 6, A; 4 for icode 9, B; else 0xF.
REQ-011 d_srcB SHALL be D_rB for icode 4, 5, 6; 4 for icode 8, 9, A, B; else 0xF.
REQ-012 d_dstE SHALL be D_rB for icode 2, 3, 6; 4 for icode 8, 9, A, B; else 0xF.
REQ-013 d_dstM SHALL be D_rA for icode 5, B; else 0xF.
REQ-014 d_valA SHALL be D_valP for icode 7 or 8, regardless of forwarding.
REQ-015 Otherwise, d_valA SHALL use the first match with d_srcA in this order: e_dstE->e_valE, M_dstM->m_valM, M_dstE->M_valE, W_dstM->W_valM, W_dstE->W_valE, else rf_valA.
REQ-016 d_valB SHALL use the same priority keyed on d_srcB; there is no valP override; the default is rf_valB.
REQ-017 A source equal to 0xF SHALL never match any forwarding tag and SHALL yield 0.
REQ-018 A forwarding tag equal to 0xF SHALL never match.
REQ-019 When several stages target the same register, the youngest SHALL win, per the order in REQ-015.
REQ-020 On each edge with rst=0 and E_bubble=0, the E register SHALL load {D_icode, D_ifun, D_valC, d_valA, d_valB, d_dstE, d_dstM, d_srcA, d_srcB, D_stat}; latency is 1 cycle.
REQ-021 On each edge with E_bubble=1, the E register SHALL load the bubble:
- icode=1, ifun=0
- valC/valA/valB=0
- dstE/dstM/srcA/srcB=0xF
- stat=1 (AOK)
REQ-022 The E register SHALL have no stall; it updates on every edge.
REQ-023 Unknown icodes (C-F) SHALL pass through with all src/dst=0xF and valA/valB=0; D_stat carries any INS status unchanged.

Reset
REQ-024 rst=1 at an edge SHALL load the bubble value of REQ-021 into every E output, overriding E_bubble and D inputs.
REQ-025 rst asserted mid-stream SHALL discard the in-flight D instruction; the first edge after rst deasserts SHALL load D normally.
REQ-026 d_srcA and d_srcB SHALL remain purely combinational and SHALL be unaffected by rst.

Verification
REQ-027 Reset: rst=1 for 2 edges with arbitrary D -> E_icode=1, E_stat=1, E_dstE=E_dstM=E_srcA=E_srcB=0xF, E_valA=E_valB=E_valC=0.
REQ-028 OPq: OPq rA=2 rB=3, rf_valA=5, rf_valB=7, no forwarding matches -> d_srcA=2, d_srcB=3; after 1 edge E_valA=5, E_valB=7, E_dstE=3, E_dstM=0xF.
REQ-029 Forwarding priority: d_srcA=2 with e_dstE=2 (valE=0x11), M_dstM=2 (m_valM=0x22), W_dstE=2 (0x33) -> E_valA=0x11; then with e_dstE=0xF -> 0x22.
REQ-030 popq: popq rA=5 -> d_srcA=d_srcB=4, E_dstE=4, E_dstM=5; M_dstE=4 with M_valE=0x80 -> E_valA=E_valB=0x80.
REQ-031 call: call, D_valP=0x1234, e_dstE=0xF -> E_valA=0x1234 and E_valB=rsp value; with e_dstE=4 (valE=0x99), E_valA still 0x1234 and E_valB=0x99.
REQ-032 Bubble: E_bubble=1 during a valid irmovq -> E holds the bubble for that edge; the next edge with E_bubble=0 loads the following instruction.

Source files
------------

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   Decode stage of a Y86-64 style pipeline. Derives register-file read
//   addresses and destination IDs from the decode pipeline register, selects
//   operand values through a forwarding network, and holds the execute-stage
//   pipeline register.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   D_*                      : decode pipeline register contents
//   d_srcA, d_srcB           : combinational register-file read addresses
//   rf_valA, rf_valB         : register-file read data for d_srcA / d_srcB
//   e_*/M_*/m_valM/W_*       : forwarding tags and values, youngest first
//   E_bubble                 : load a bubble into the execute register
//   E_*                      : registered execute pipeline register
// -----------------------------------------------------------------------------
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  D_ifun,
    input  logic [3:0]  D_rA,
    input  logic [3:0]  D_rB,
    input  logic [63:0] D_valC,
    input  logic [63:0] D_valP,
    input  logic [3:0]  D_stat,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB,
    input  logic [63:0] rf_valA,
    input  logic [63:0] rf_valB,
    input  logic [3:0]  e_dstE,
    input  logic [63:0] e_valE,
    input  logic [3:0]  M_dstE,
    input  logic [63:0] M_valE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] m_valM,
    input  logic [3:0]  W_dstE,
    input  logic [63:0] W_valE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_valM,
    input  logic        E_bubble,
    output logic [3:0]  E_icode,
    output logic [3:0]  E_ifun,
    output logic [63:0] E_valC,
    output logic [63:0] E_valA,
    output logic [63:0] E_valB,
    output logic [3:0]  E_dstE,
    output logic [3:0]  E_dstM,
    output logic [3:0]  E_srcA,
    output logic [3:0]  E_srcB,
    output logic [3:0]  E_stat
);

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] STAT_AOK = 4'h1;

    logic [3:0]  d_dstE;
    logic [3:0]  d_dstM;
    logic [63:0] d_valA;
    logic [63:0] d_valB;

    logic [3:0]  e_icode_d, e_icode_q;
    logic [3:0]  e_ifun_d,  e_ifun_q;
    logic [63:0] e_valC_d,  e_valC_q;
    logic [63:0] e_valA_d,  e_valA_q;
    logic [63:0] e_valB_d,  e_valB_q;
    logic [3:0]  e_dstE_d,  e_dstE_q;
    logic [3:0]  e_dstM_d,  e_dstM_q;
    logic [3:0]  e_srcA_d,  e_srcA_q;
    logic [3:0]  e_srcB_d,  e_srcB_q;
    logic [3:0]  e_stat_d,  e_stat_q;

    // Register ID selection
    always_comb begin
        d_srcA = REG_NONE;
        d_srcB = REG_NONE;
        d_dstE = REG_NONE;
        d_dstM = REG_NONE;

        case (D_icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: d_srcA = D_rA;
            I_RET, I_POPQ:                      d_srcA = REG_RSP;
            default:                            d_srcA = REG_NONE;
        endcase

        case (D_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:          d_srcB = D_rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     d_srcB = REG_RSP;
            default:                            d_srcB = REG_NONE;
        endcase

        case (D_icode)
            I_RRMOVQ, I_IRMOVQ, I_OPQ:          d_dstE = D_rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     d_dstE = REG_RSP;
            default:                            d_dstE = REG_NONE;
        endcase

        case (D_icode)
            I_MRMOVQ, I_POPQ:                   d_dstM = D_rA;
            default:                            d_dstM = REG_NONE;
        endcase
    end

    // Forwarding select: youngest producer first. A "none" source yields 0;
    // since the source is then never equal to a real ID, a "none" tag can
    // only match a "none" source, which is filtered out first.
    function automatic logic [63:0] fwd_sel(input logic [3:0]  src,
                                            input logic [63:0] rf_val,
                                            input logic [3:0]  t_eE, input logic [63:0] v_eE,
                                            input logic [3:0]  t_MM, input logic [63:0] v_MM,
                                            input logic [3:0]  t_ME, input logic [63:0] v_ME,
                                            input logic [3:0]  t_WM, input logic [63:0] v_WM,
                                            input logic [3:0]  t_WE, input logic [63:0] v_WE);
        if (src == REG_NONE)  return '0;
        else if (src == t_eE) return v_eE;
        else if (src == t_MM) return v_MM;
        else if (src == t_ME) return v_ME;
        else if (src == t_WM) return v_WM;
        else if (src == t_WE) return v_WE;
        else                  return rf_val;
    endfunction

    always_comb begin
        d_valA = '0;
        d_valB = '0;
        if (D_icode == I_JXX || D_icode == I_CALL)
            d_valA = D_valP;
        else
            d_valA = fwd_sel(d_srcA, rf_valA, e_dstE, e_valE, M_dstM, m_valM,
                             M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
        d_valB = fwd_sel(d_srcB, rf_valB, e_dstE, e_valE, M_dstM, m_valM,
                         M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
    end

    // Execute register next state: bubble or decoded instruction
    always_comb begin
        e_icode_d = D_icode;
        e_ifun_d  = D_ifun;
        e_valC_d  = D_valC;
        e_valA_d  = d_valA;
        e_valB_d  = d_valB;
        e_dstE_d  = d_dstE;
        e_dstM_d  = d_dstM;
        e_srcA_d  = d_srcA;
        e_srcB_d  = d_srcB;
        e_stat_d  = D_stat;
        if (E_bubble) begin
            e_icode_d = I_NOP;
            e_ifun_d  = '0;
            e_valC_d  = '0;
            e_valA_d  = '0;
            e_valB_d  = '0;
            e_dstE_d  = REG_NONE;
            e_dstM_d  = REG_NONE;
            e_srcA_d  = REG_NONE;
            e_srcB_d  = REG_NONE;
            e_stat_d  = STAT_AOK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_icode_q <= I_NOP;
            e_ifun_q  <= '0;
            e_valC_q  <= '0;
            e_valA_q  <= '0;
            e_valB_q  <= '0;
            e_dstE_q  <= REG_NONE;
            e_dstM_q  <= REG_NONE;
            e_srcA_q  <= REG_NONE;
            e_srcB_q  <= REG_NONE;
            e_stat_q  <= STAT_AOK;
        end else begin
            e_icode_q <= e_icode_d;
            e_ifun_q  <= e_ifun_d;
            e_valC_q  <= e_valC_d;
            e_valA_q  <= e_valA_d;
            e_valB_q  <= e_valB_d;
            e_dstE_q  <= e_dstE_d;
            e_dstM_q  <= e_dstM_d;
            e_srcA_q  <= e_srcA_d;
            e_srcB_q  <= e_srcB_d;
            e_stat_q  <= e_stat_d;
        end
    end

    assign E_icode = e_icode_q;
    assign E_ifun  = e_ifun_q;
    assign E_valC  = e_valC_q;
    assign E_valA  = e_valA_q;
    assign E_valB  = e_valB_q;
    assign E_dstE  = e_dstE_q;
    assign E_dstM  = e_dstM_q;
    assign E_srcA  = e_srcA_q;
    assign E_srcB  = e_srcB_q;
    assign E_stat  = e_stat_q;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//   Directed self-checking bench for decode_stage. Inputs change mid-cycle,
//   registered outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB, D_stat;
    logic [63:0] D_valC, D_valP;
    logic [3:0]  d_srcA, d_srcB;
    logic [63:0] rf_valA, rf_valB;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic        E_bubble;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB, E_stat;
    logic [63:0] E_valC, E_valA, E_valB;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .rf_valA(rf_valA), .rf_valB(rf_valB),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_valE(M_valE),
        .M_dstM(M_dstM), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_valE(W_valE),
        .W_dstM(W_dstM), .W_valM(W_valM),
        .E_bubble(E_bubble),
        .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
        .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .E_srcA(E_srcA), .E_srcB(E_srcB), .E_stat(E_stat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_fwd();
        e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
        e_valE = '0;   M_valE = '0;   m_valM = '0;   W_valE = '0;   W_valM = '0;
    endtask

    task automatic set_d(input logic [3:0] ic, input logic [3:0] rA, input logic [3:0] rB,
                         input logic [63:0] valC, input logic [63:0] valP);
        D_icode = ic; D_ifun = 4'h0; D_rA = rA; D_rB = rB;
        D_valC = valC; D_valP = valP; D_stat = 4'h1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".icode"}, 64'(E_icode), 64'h1);
        chk({tag, ".ifun"},  64'(E_ifun),  64'h0);
        chk({tag, ".valC"},  E_valC, 64'h0);
        chk({tag, ".valA"},  E_valA, 64'h0);
        chk({tag, ".valB"},  E_valB, 64'h0);
        chk({tag, ".dstE"},  64'(E_dstE), 64'hF);
        chk({tag, ".dstM"},  64'(E_dstM), 64'hF);
        chk({tag, ".srcA"},  64'(E_srcA), 64'hF);
        chk({tag, ".srcB"},  64'(E_srcB), 64'hF);
        chk({tag, ".stat"},  64'(E_stat), 64'h1);
    endtask

    initial begin
        // Reset with a live OPq on D
        rst = 1'b1; E_bubble = 1'b0;
        clear_fwd();
        rf_valA = 64'hAA; rf_valB = 64'hBB;
        set_d(4'h6, 4'h2, 4'h3, 64'h55, 64'h66);
        #2;
        step(); step();
        chk_bubble("reset");
        chk("reset.srcA_comb", 64'(d_srcA), 64'h2);

        // OPq rA=2 rB=3, no forwarding
        @(negedge clk);
        rst = 1'b0;
        rf_valA = 64'h5; rf_valB = 64'h7;
        #1;
        chk("opq.d_srcA", 64'(d_srcA), 64'h2);
        chk("opq.d_srcB", 64'(d_srcB), 64'h3);
        step();
        chk("opq.icode", 64'(E_icode), 64'h6);
        chk("opq.valA",  E_valA, 64'h5);
        chk("opq.valB",  E_valB, 64'h7);
        chk("opq.dstE",  64'(E_dstE), 64'h3);
        chk("opq.dstM",  64'(E_dstM), 64'hF);
        chk("opq.srcA",  64'(E_srcA), 64'h2);
        chk("opq.valC",  E_valC, 64'h55);

        // Forwarding priority on srcA=2
        @(negedge clk);
        e_dstE = 4'h2; e_valE = 64'h11;
        M_dstM = 4'h2; m_valM = 64'h22;
        W_dstE = 4'h2; W_valE = 64'h33;
        step();
        chk("fwd.eE", E_valA, 64'h11);
        @(negedge clk);
        e_dstE = 4'hF;
        step();
        chk("fwd.MM", E_valA, 64'h22);
        @(negedge clk);
        M_dstM = 4'hF; M_dstE = 4'h2; M_valE = 64'h44;
        step();
        chk("fwd.ME", E_valA, 64'h44);
        @(negedge clk);
        M_dstE = 4'hF; W_dstM = 4'h2; W_valM = 64'h55;
        step();
        chk("fwd.WM", E_valA, 64'h55);
        @(negedge clk);
        W_dstM = 4'hF;
        step();
        chk("fwd.WE", E_valA, 64'h33);
        chk("fwd.valB_rf", E_valB, 64'h7);

        // popq rA=5
        @(negedge clk);
        clear_fwd();
        set_d(4'hB, 4'h5, 4'hF, 64'h0, 64'h0);
        M_dstE = 4'h4; M_valE = 64'h80;
        #1;
        chk("popq.d_srcA", 64'(d_srcA), 64'h4);
        chk("popq.d_srcB", 64'(d_srcB), 64'h4);
        step();
        chk("popq.dstE", 64'(E_dstE), 64'h4);
        chk("popq.dstM", 64'(E_dstM), 64'h5);
        chk("popq.valA", E_valA, 64'h80);
        chk("popq.valB", E_valB, 64'h80);

        // call: valA is valP regardless of forwarding
        @(negedge clk);
        clear_fwd();
        set_d(4'h8, 4'hF, 4'hF, 64'h2000, 64'h1234);
        rf_valA = 64'h9; rf_valB = 64'h700;
        step();
        chk("call.valA", E_valA, 64'h1234);
        chk("call.valB", E_valB, 64'h700);
        chk("call.dstE", 64'(E_dstE), 64'h4);
        chk("call.srcA", 64'(E_srcA), 64'hF);
        @(negedge clk);
        e_dstE = 4'h4; e_valE = 64'h99;
        step();
        chk("call_fwd.valA", E_valA, 64'h1234);
        chk("call_fwd.valB", E_valB, 64'h99);

        // Bubble during irmovq, then rrmovq loads normally
        @(negedge clk);
        clear_fwd();
        set_d(4'h3, 4'hF, 4'h7, 64'hABC, 64'h0);
        E_bubble = 1'b1;
        step();
        chk_bubble("bubble");
        @(negedge clk);
        E_bubble = 1'b0;
        set_d(4'h2, 4'h1, 4'h9, 64'h0, 64'h0);
        rf_valA = 64'h31; rf_valB = 64'h77;
        step();
        chk("rrmovq.icode", 64'(E_icode), 64'h2);
        chk("rrmovq.valA",  E_valA, 64'h31);
        chk("rrmovq.valB",  E_valB, 64'h0);
        chk("rrmovq.dstE",  64'(E_dstE), 64'h9);
        chk("rrmovq.srcB",  64'(E_srcB), 64'hF);

        // irmovq without bubble
        @(negedge clk);
        set_d(4'h3, 4'hF, 4'h7, 64'hABC, 64'h0);
        step();
        chk("irmovq.valC", E_valC, 64'hABC);
        chk("irmovq.dstE", 64'(E_dstE), 64'h7);
        chk("irmovq.srcA", 64'(E_srcA), 64'hF);

        // Unknown icode with INS status; "none" forwarding tags never match
        @(negedge clk);
        set_d(4'hD, 4'h3, 4'h3, 64'h0, 64'h0);
        D_stat = 4'h4;
        e_dstE = 4'hF; e_valE = 64'h77;
        step();
        chk("unk.icode", 64'(E_icode), 64'hD);
        chk("unk.stat",  64'(E_stat), 64'h4);
        chk("unk.valA",  E_valA, 64'h0);
        chk("unk.valB",  E_valB, 64'h0);
        chk("unk.dstE",  64'(E_dstE), 64'hF);
        chk("unk.srcA",  64'(E_srcA), 64'hF);

        // Mid-stream reset overrides D, then D loads on first edge after
        @(negedge clk);
        clear_fwd();
        set_d(4'h6, 4'h2, 4'h3, 64'h0, 64'h0);
        rf_valA = 64'h5; rf_valB = 64'h7;
        rst = 1'b1;
        step();
        chk("midrst.icode", 64'(E_icode), 64'h1);
        chk("midrst.valA",  E_valA, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("postrst.icode", 64'(E_icode), 64'h6);
        chk("postrst.valB",  E_valB, 64'h7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
